// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and the FIFO entry type for the instruction fetch stage.
// Holds the ADDR_WIDTH / DATA_WIDTH / NOP / ZERO constants of the surrounding core.
package if_fetch_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [DATA_WIDTH-1:0] NOP  = 32'h0000_0013;
   localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

   function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
      return a & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO used both for returned {addr, inst} pairs and for in-flight request addresses.
// Head data is read straight from storage; clear empties the queue in one cycle.
module if_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign data_o  = r_mem[r_rptr];

   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   // NOTE: storage carries no reset; the count alone decides which slots are meaningful.
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) begin
         r_mem[r_wptr] <= data_i;
      end
   end

   // NOTE: clocked state uses <= so every flop samples the pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to imem and
// buffers responses for if_id; a redirect flushes the buffer and drops in-flight responses.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
   parameter int                    DEPTH      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   output logic                  inst_valid_o,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_addr_o,
   input  logic                  inst_ready_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [CW-1:0]         r_drop;

   logic [CW-1:0]         w_fifo_count;
   logic [CW-1:0]         w_out_count;
   logic [CW:0]           w_inflight;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic                  w_aq_full;
   logic                  w_aq_empty;
   logic                  w_credit;
   logic                  w_grant;
   logic                  w_rsp;
   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_WIDTH-1:0] w_aq_addr;
   fetch_entry_t          w_push_entry;
   fetch_entry_t          w_head;

   // Buffered plus outstanding instructions may never exceed DEPTH, so the FIFO cannot overflow.
   assign w_inflight = {1'b0, w_fifo_count} + {1'b0, w_out_count};
   assign w_credit   = !w_fifo_full && !w_aq_full && (w_inflight < (CW+1)'(DEPTH));

   assign imem_req_o  = !rst_i && !jump_en_i && w_credit;
   assign imem_addr_o = r_pc;
   assign w_grant     = imem_req_o && imem_gnt_i;

   // A response with nothing outstanding (e.g. left over from before reset) is ignored.
   assign w_rsp  = imem_rvalid_i && !w_aq_empty;
   assign w_push = w_rsp && (r_drop == '0) && !jump_en_i;
   assign w_pop  = !w_fifo_empty && inst_ready_i && !jump_en_i;

   assign w_push_entry = '{addr: w_aq_addr, inst: imem_rdata_i};

   assign inst_valid_o = !w_fifo_empty;
   assign inst_o       = w_fifo_empty ? NOP  : w_head.inst;
   assign inst_addr_o  = w_fifo_empty ? ZERO : w_head.addr;

   // Address queue: one entry per granted request, retired by its response even when dropped.
   if_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (DEPTH)
   ) u_addr_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_grant),
      .pop_i   (w_rsp),
      .clear_i (1'b0),
      .data_i  (r_pc),
      .data_o  (w_aq_addr),
      .full_o  (w_aq_full),
      .empty_o (w_aq_empty),
      .count_o (w_out_count)
   );

   if_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_q (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .clear_i (jump_en_i),
      .data_i  (w_push_entry),
      .data_o  (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pc <= RESET_ADDR;
      end else if (jump_en_i) begin
         r_pc <= word_align(jump_addr_i);
      end else if (w_grant) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   // A redirect drops every response still owed, minus the one retiring in this very cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_drop <= '0;
      end else if (jump_en_i) begin
         r_drop <= w_out_count - CW'(w_rsp);
      end else if (w_rsp && (r_drop != '0)) begin
         r_drop <= r_drop - CW'(1);
      end
   end

endmodule
